// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-flow FSM and frame-synchronous move scheduler.
// It issues one step_req per `period` frames and waits for a step_ack handshake.
// It also tracks score, speed level and a sticky acknowledge-timeout flag.
module snake_game_ctrl #(
    parameter int BASE_PERIOD   = 20,
    parameter int MIN_PERIOD    = 4,
    parameter int SPEEDUP_EVERY = 4,
    parameter int SCORE_W       = 8,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               collide,
    input  logic               food_eaten,
    input  logic               step_ack,
    output logic               step_req,
    output logic               body_clear,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level,
    output logic               timeout_err
);

    localparam logic [6:0] BASE_P  = 7'(BASE_PERIOD);
    localparam logic [6:0] MIN_P   = 7'(MIN_PERIOD);
    localparam logic [7:0] ACK_LIM = 8'(ACK_TIMEOUT - 1);
    localparam logic [3:0] SPD_LIM = 4'(SPEEDUP_EVERY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_STEP  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [6:0]         frame_cnt_reg, frame_cnt_next;
    logic [3:0]         food_cnt_reg, food_cnt_next;
    logic [7:0]         ack_cnt_reg, ack_cnt_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [3:0]         level_reg, level_next;
    logic               timeout_reg, timeout_next;
    logic               step_req_reg, step_req_next;
    logic               body_clear_reg, body_clear_next;
    logic [1:0]         game_state_reg, game_state_next;

    logic [6:0] two_lvl;
    logic [6:0] period;
    logic       frame_hit;
    logic       active;
    logic       eat;
    logic       ack_expired;

    // Move period shrinks by two frames per level; compare first so it never underflows.
    assign two_lvl     = {2'b00, level_reg, 1'b0};
    assign period      = ((two_lvl + MIN_P) < BASE_P) ? (BASE_P - two_lvl) : MIN_P;
    // >= rather than == so a period that shrank below the running count still fires.
    assign frame_hit   = frame_start && (frame_cnt_reg >= (period - 7'd1));
    assign active      = (state_reg == S_PLAY) || (state_reg == S_STEP);
    assign eat         = active && !collide && food_eaten;
    assign ack_expired = (state_reg == S_STEP) && !step_ack && (ack_cnt_reg == ACK_LIM);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; collide outranks every other event while the game runs.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_OVER: begin
                if (start_btn) state_next = S_PLAY;
            end
            S_PLAY: begin
                if (collide)        state_next = S_OVER;
                else if (pause_btn) state_next = S_PAUSE;
                else if (frame_hit) state_next = S_STEP;
            end
            S_STEP: begin
                if (collide)          state_next = S_OVER;
                else if (step_ack)    state_next = S_PLAY;
                else if (ack_expired) state_next = S_OVER;
            end
            S_PAUSE: begin
                if (pause_btn) state_next = S_PLAY;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output and datapath next values; all of them are registered below.
    always_comb begin
        frame_cnt_next  = frame_cnt_reg;
        food_cnt_next   = food_cnt_reg;
        ack_cnt_next    = ack_cnt_reg;
        score_next      = score_reg;
        level_next      = level_reg;
        timeout_next    = timeout_reg;
        body_clear_next = 1'b0;

        case (state_reg)
            S_IDLE, S_OVER: begin
                if (start_btn) begin
                    frame_cnt_next  = '0;
                    food_cnt_next   = '0;
                    score_next      = '0;
                    level_next      = '0;
                    timeout_next    = 1'b0;
                    body_clear_next = 1'b1;
                end
            end
            S_PLAY: begin
                ack_cnt_next = '0;
                if (!collide && !pause_btn && frame_start) begin
                    frame_cnt_next = frame_hit ? 7'd0 : frame_cnt_reg + 7'd1;
                end
            end
            S_STEP: begin
                if (!collide) begin
                    // Frames keep counting while the body logic works; saturate to avoid wrap.
                    if (frame_start && frame_cnt_reg != 7'h7F) begin
                        frame_cnt_next = frame_cnt_reg + 7'd1;
                    end
                    ack_cnt_next = ack_cnt_reg + 8'd1;
                    if (ack_expired) timeout_next = 1'b1;
                end
            end
            default: ;
        endcase

        if (eat) begin
            if (score_reg != '1) score_next = score_reg + 1'b1;
            if (food_cnt_reg >= SPD_LIM) begin
                food_cnt_next = '0;
                if (level_reg != 4'hF) level_next = level_reg + 4'd1;
            end else begin
                food_cnt_next = food_cnt_reg + 4'd1;
            end
        end

        step_req_next = (state_next == S_STEP);
        case (state_next)
            S_IDLE:         game_state_next = 2'b00;
            S_PLAY, S_STEP: game_state_next = 2'b01;
            S_PAUSE:        game_state_next = 2'b10;
            default:        game_state_next = 2'b11;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt_reg  <= '0;
            food_cnt_reg   <= '0;
            ack_cnt_reg    <= '0;
            score_reg      <= '0;
            level_reg      <= '0;
            timeout_reg    <= 1'b0;
            step_req_reg   <= 1'b0;
            body_clear_reg <= 1'b0;
            game_state_reg <= 2'b00;
        end else begin
            frame_cnt_reg  <= frame_cnt_next;
            food_cnt_reg   <= food_cnt_next;
            ack_cnt_reg    <= ack_cnt_next;
            score_reg      <= score_next;
            level_reg      <= level_next;
            timeout_reg    <= timeout_next;
            step_req_reg   <= step_req_next;
            body_clear_reg <= body_clear_next;
            game_state_reg <= game_state_next;
        end
    end

    assign step_req    = step_req_reg;
    assign body_clear  = body_clear_reg;
    assign game_state  = game_state_reg;
    assign score       = score_reg;
    assign level       = level_reg;
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: a directed vector table plus hand sequences
// for step timing, acknowledge timeout, score/level saturation and reset mid-step.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       collide = 1'b0;
    logic       food_eaten = 1'b0;
    logic       step_ack = 1'b0;
    logic       step_req;
    logic       body_clear;
    logic [1:0] game_state;
    logic [7:0] score;
    logic [3:0] level;
    logic       timeout_err;

    int total = 0;
    int bad = 0;

    snake_game_ctrl dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .start_btn(start_btn),
        .pause_btn(pause_btn), .collide(collide), .food_eaten(food_eaten),
        .step_ack(step_ack), .step_req(step_req), .body_clear(body_clear),
        .game_state(game_state), .score(score), .level(level), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         frames;
        logic       st, pb, col, food, ack;
        logic [1:0] gs;
        logic       req;
        int         sc;
        int         lv;
        logic       bc;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, pass the edge, sample 1ns later, release inputs.
    task automatic cyc(input logic fs, input logic st, input logic pb,
                       input logic col, input logic food, input logic ack);
        frame_start = fs; start_btn = st; pause_btn = pb;
        collide = col; food_eaten = food; step_ack = ack;
        @(posedge clk);
        #1;
        frame_start = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
        collide = 1'b0; food_eaten = 1'b0; step_ack = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //           fr  st pb co fd ak  gs     req sc lv bc
        vecs[0]  = '{0,  1, 0, 0, 0, 0, 2'b01, 0,  0, 0, 1};  // start
        vecs[1]  = '{19, 0, 0, 0, 0, 0, 2'b01, 0,  0, 0, 0};
        vecs[2]  = '{1,  0, 0, 0, 0, 0, 2'b01, 1,  0, 0, 0};  // 20th frame
        vecs[3]  = '{0,  0, 0, 0, 1, 1, 2'b01, 0,  1, 0, 0};
        vecs[4]  = '{20, 0, 0, 0, 0, 0, 2'b01, 1,  1, 0, 0};
        vecs[5]  = '{0,  0, 0, 0, 1, 1, 2'b01, 0,  2, 0, 0};
        vecs[6]  = '{20, 0, 0, 0, 0, 0, 2'b01, 1,  2, 0, 0};
        vecs[7]  = '{0,  0, 0, 0, 1, 1, 2'b01, 0,  3, 0, 0};
        vecs[8]  = '{20, 0, 0, 0, 0, 0, 2'b01, 1,  3, 0, 0};
        vecs[9]  = '{0,  0, 0, 0, 1, 1, 2'b01, 0,  4, 1, 0};  // level 1, period 18
        vecs[10] = '{17, 0, 0, 0, 0, 0, 2'b01, 0,  4, 1, 0};
        vecs[11] = '{1,  0, 0, 0, 0, 0, 2'b01, 1,  4, 1, 0};
        vecs[12] = '{0,  0, 0, 0, 0, 1, 2'b01, 0,  4, 1, 0};
        vecs[13] = '{10, 0, 1, 0, 0, 0, 2'b10, 0,  4, 1, 0};  // pause after 10
        vecs[14] = '{50, 0, 0, 0, 0, 0, 2'b10, 0,  4, 1, 0};
        vecs[15] = '{0,  0, 1, 0, 0, 0, 2'b01, 0,  4, 1, 0};  // resume
        vecs[16] = '{7,  0, 0, 0, 0, 0, 2'b01, 0,  4, 1, 0};
        vecs[17] = '{1,  0, 0, 0, 0, 0, 2'b01, 1,  4, 1, 0};
        vecs[18] = '{0,  0, 1, 0, 0, 0, 2'b01, 1,  4, 1, 0};  // pause in STEP ignored
        vecs[19] = '{0,  0, 0, 1, 1, 0, 2'b11, 0,  4, 1, 0};  // collide beats food
        vecs[20] = '{0,  0, 0, 1, 0, 0, 2'b11, 0,  4, 1, 0};
        vecs[21] = '{0,  0, 0, 0, 1, 0, 2'b11, 0,  4, 1, 0};
        vecs[22] = '{0,  0, 1, 0, 0, 0, 2'b11, 0,  4, 1, 0};
        vecs[23] = '{0,  1, 1, 0, 0, 0, 2'b01, 0,  0, 0, 1};  // start wins over pause

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.gs", game_state, 0);
        chk("rst.req", step_req, 0);
        chk("rst.score", score, 0);
        chk("rst.level", level, 0);
        chk("rst.to", timeout_err, 0);
        chk("rst.bc", body_clear, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("idle.gs", game_state, 0);

        for (int i = 0; i < 24; i++) begin
            frames(vecs[i].frames);
            cyc(0, vecs[i].st, vecs[i].pb, vecs[i].col, vecs[i].food, vecs[i].ack);
            chk($sformatf("vec%0d.gs", i), game_state, vecs[i].gs);
            chk($sformatf("vec%0d.req", i), step_req, vecs[i].req);
            chk($sformatf("vec%0d.score", i), score, vecs[i].sc);
            chk($sformatf("vec%0d.level", i), level, vecs[i].lv);
            chk($sformatf("vec%0d.bc", i), body_clear, vecs[i].bc);
            $display("vec %0d: gs=%0d req=%0d score=%0d level=%0d bc=%0d",
                     i, game_state, step_req, score, level, body_clear);
        end

        // Exact step timing and ack latency
        cyc(0, 0, 0, 0, 0, 0);
        chk("bc.one", body_clear, 0);
        frames(19);
        chk("t.pre", step_req, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t.rise", step_req, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t.hold1", step_req, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t.hold2", step_req, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t.ack", step_req, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t.strayack.gs", game_state, 1);
        chk("t.strayack.req", step_req, 0);
        frames(19);
        chk("t.next.pre", step_req, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t.next.rise", step_req, 1);
        $display("timing: step issued after 20 frames");

        // Withhold ack until timeout
        n = 0;
        while (step_req && n < 400) begin
            n++;
            cyc(0, 0, 0, 0, 0, 0);
        end
        chk("to.cycles", n, 255);
        chk("to.gs", game_state, 3);
        chk("to.err", timeout_err, 1);
        $display("timeout: req high %0d cycles err=%0d", n, timeout_err);
        cyc(0, 1, 0, 0, 0, 0);
        chk("to.restart.gs", game_state, 1);
        chk("to.restart.err", timeout_err, 0);

        // Level ramp and period clamp
        for (int k = 0; k < 32; k++) cyc(0, 0, 0, 0, 1, 0);
        chk("lv8.score", score, 32);
        chk("lv8.level", level, 8);
        frames(3);
        chk("lv8.pre", step_req, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("lv8.rise", step_req, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("lv8.ack", step_req, 0);
        for (int k = 0; k < 228; k++) cyc(0, 0, 0, 0, 1, 0);
        chk("sat.score", score, 255);
        chk("sat.level", level, 15);
        frames(3);
        chk("sat.pre", step_req, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("sat.rise", step_req, 1);
        $display("saturation: score=%0d level=%0d", score, level);

        // Reset while a step is pending
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        chk("rs.req", step_req, 0);
        chk("rs.gs", game_state, 0);
        chk("rs.score", score, 0);
        chk("rs.level", level, 0);
        chk("rs.to", timeout_err, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        $display("reset-in-step: gs=%0d req=%0d", game_state, step_req);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
